// File: rtl/register_access_ctrl_if.sv
// Register access controller bus interface.
// Carries the command handshake (valid/ready, op, rx, ry, imm), the register
// bank control/data signals and the completion status (done, err).
//   master : command issuer and register bank (drives commands and bank read data)
//   slave  : the controller (drives cmd_ready, bank controls, done, err)
interface register_access_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [SEL_W-1:0]  cmd_rx;
    logic [SEL_W-1:0]  cmd_ry;
    logic [DATA_W-1:0] cmd_imm;

    logic [SEL_W-1:0]  bank_rx_sel;
    logic [SEL_W-1:0]  bank_ry_sel;
    logic              bank_read_en;
    logic              bank_write_en;
    logic              bank_indirect_en;
    logic [DATA_W-1:0] bank_wr_data;
    logic [DATA_W-1:0] bank_rx_data;
    logic [DATA_W-1:0] bank_ry_data;
    logic [DATA_W-1:0] bank_bus_data;

    logic              done;
    logic              err;

    modport master (
        output cmd_valid, cmd_op, cmd_rx, cmd_ry, cmd_imm,
        output bank_rx_data, bank_ry_data, bank_bus_data,
        input  cmd_ready, bank_rx_sel, bank_ry_sel, bank_read_en,
        input  bank_write_en, bank_indirect_en, bank_wr_data, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rx, cmd_ry, cmd_imm,
        input  bank_rx_data, bank_ry_data, bank_bus_data,
        output cmd_ready, bank_rx_sel, bank_ry_sel, bank_read_en,
        output bank_write_en, bank_indirect_en, bank_wr_data, done, err
    );
endinterface

// File: rtl/register_access_ctrl.sv
// Register access controller.
// Accepts one command at a time (WRITE_IMM, COPY, IND_LOAD, SWAP) and
// sequences the register bank controls to carry it out, then pulses done
// (with err for an aborted IND_LOAD).
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : register_access_ctrl_if.slave (command handshake, bank controls, status)
//
// state | meaning
// IDLE  | cmd_ready=1, waiting for cmd_valid; latches the command fields
// EXEC  | first (or only) bank access of the latched command
// SWAP2 | second write of SWAP: old rx value (tmp) into ry
// DONE  | done pulse for one cycle, err reports an aborted command
module register_access_ctrl #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    register_access_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXEC, SWAP2, DONE} state_t;

    localparam logic [1:0] OP_WRITE_IMM = 2'b00;
    localparam logic [1:0] OP_COPY      = 2'b01;
    localparam logic [1:0] OP_IND_LOAD  = 2'b10;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [SEL_W-1:0]  rx_q, rx_d;
    logic [SEL_W-1:0]  ry_q, ry_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [DATA_W-1:0] tmp_q, tmp_d;
    logic              err_q, err_d;

    logic              ready_c, read_en_c, write_en_c, indirect_en_c, done_c, err_c;
    logic [SEL_W-1:0]  rx_sel_c, ry_sel_c;
    logic [DATA_W-1:0] wr_data_c;
    logic              ptr_oob;

    // The pointer read from ry is out of range when any bit above the
    // selector width is set; a data word no wider than the selector can
    // never point outside the bank.
    assign ptr_oob = (DATA_W > SEL_W) ? ((bus.bank_ry_data >> SEL_W) != '0) : 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            rx_q    <= '0;
            ry_q    <= '0;
            imm_q   <= '0;
            tmp_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
            imm_q   <= imm_d;
            tmp_q   <= tmp_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        rx_d          = rx_q;
        ry_d          = ry_q;
        imm_d         = imm_q;
        tmp_d         = tmp_q;
        err_d         = err_q;
        ready_c       = 1'b0;
        read_en_c     = 1'b0;
        write_en_c    = 1'b0;
        indirect_en_c = 1'b0;
        done_c        = 1'b0;
        err_c         = 1'b0;
        rx_sel_c      = '0;
        ry_sel_c      = '0;
        wr_data_c     = '0;

        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.cmd_valid) begin
                    op_d    = bus.cmd_op;
                    rx_d    = bus.cmd_rx;
                    ry_d    = bus.cmd_ry;
                    imm_d   = bus.cmd_imm;
                    err_d   = 1'b0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rx_sel_c = rx_q;
                state_d  = DONE;
                case (op_q)
                    OP_WRITE_IMM: begin
                        wr_data_c  = imm_q;
                        write_en_c = 1'b1;
                    end
                    OP_COPY, OP_IND_LOAD: begin
                        read_en_c     = 1'b1;
                        indirect_en_c = (op_q == OP_IND_LOAD);
                        ry_sel_c      = ry_q;
                        wr_data_c     = bus.bank_bus_data;
                        if ((op_q == OP_IND_LOAD) && ptr_oob) begin
                            err_d = 1'b1;
                        end else begin
                            write_en_c = 1'b1;
                        end
                    end
                    default: begin
                        // SWAP, first half: ry value into rx, keep old rx in tmp.
                        ry_sel_c   = ry_q;
                        wr_data_c  = bus.bank_ry_data;
                        write_en_c = 1'b1;
                        tmp_d      = bus.bank_rx_data;
                        state_d    = SWAP2;
                    end
                endcase
            end
            SWAP2: begin
                rx_sel_c   = ry_q;
                wr_data_c  = tmp_q;
                write_en_c = 1'b1;
                state_d    = DONE;
            end
            default: begin
                done_c  = 1'b1;
                err_c   = err_q;
                state_d = IDLE;
            end
        endcase
    end

    // Reset gates the handshake and write strobe combinationally so a
    // mid-cycle reset drops them without waiting for the state register.
    assign bus.cmd_ready        = ready_c & ~rst;
    assign bus.bank_read_en     = read_en_c & ~rst;
    assign bus.bank_write_en    = write_en_c & ~rst;
    assign bus.bank_indirect_en = indirect_en_c & ~rst;
    assign bus.done             = done_c & ~rst;
    assign bus.err              = err_c & ~rst;
    assign bus.bank_rx_sel      = rx_sel_c;
    assign bus.bank_ry_sel      = ry_sel_c;
    assign bus.bank_wr_data     = wr_data_c;
endmodule

// File: tb/tb_register_access_ctrl.sv
// Bench for register_access_ctrl: drives commands into the controller, hosts
// a behavioural register bank, and checks writes, done/err and latency
// against a command-level register model through a scoreboard.
module tb_register_access_ctrl;
    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;
    localparam int NREG   = 8;

    localparam logic [1:0] WR = 2'b00, CP = 2'b01, IL = 2'b10, SW = 2'b11;

    logic clk = 1'b0;
    logic rst;
    logic bank_init;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    register_access_ctrl_if #(.DATA_W(DATA_W), .SEL_W(SEL_W)) ifc ();

    register_access_ctrl #(.DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // Behavioural register bank with combinational reads.
    logic [7:0] bank [NREG];
    always @(posedge clk) begin
        if (bank_init) begin
            for (int i = 0; i < NREG; i++) bank[i] <= 8'h00;
        end else if (ifc.bank_write_en) begin
            bank[ifc.bank_rx_sel] <= ifc.bank_wr_data;
        end
    end
    assign ifc.bank_rx_data  = bank[ifc.bank_rx_sel];
    assign ifc.bank_ry_data  = bank[ifc.bank_ry_sel];
    assign ifc.bank_bus_data = !ifc.bank_read_en ? 8'h00 :
                               ifc.bank_indirect_en ? bank[bank[ifc.bank_ry_sel][2:0]] :
                               bank[ifc.bank_ry_sel];

    // Command-level reference: register contents after each accepted command.
    logic [7:0] model [NREG];

    typedef struct {
        int          lat;
        logic        err;
        int          acc;
        logic [63:0] snap;
    } exp_t;

    exp_t        sq[$];
    logic [10:0] wq[$];

    function automatic logic [63:0] pack_model();
        logic [63:0] v;
        for (int i = 0; i < NREG; i++) v[i*8 +: 8] = model[i];
        return v;
    endfunction

    function automatic logic [63:0] pack_bank();
        logic [63:0] v;
        for (int i = 0; i < NREG; i++) v[i*8 +: 8] = bank[i];
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Apply the command's architectural effect to the model and queue the
    // expected bank writes and completion.
    task automatic accept_push(input logic [1:0] op, input logic [2:0] rx,
                               input logic [2:0] ry, input logic [7:0] imm);
        exp_t e;
        logic [7:0] a, b;
        e.lat = 2;
        e.err = 1'b0;
        e.acc = cyc;
        case (op)
            WR: begin
                wq.push_back({rx, imm});
                model[rx] = imm;
            end
            CP: begin
                a = model[ry];
                wq.push_back({rx, a});
                model[rx] = a;
            end
            IL: begin
                if (model[ry] >= NREG) begin
                    e.err = 1'b1;
                end else begin
                    a = model[model[ry]];
                    wq.push_back({rx, a});
                    model[rx] = a;
                end
            end
            default: begin
                a = model[rx];
                b = model[ry];
                wq.push_back({rx, b});
                wq.push_back({ry, a});
                model[rx] = b;
                model[ry] = a;
                e.lat = 3;
            end
        endcase
        e.snap = pack_model();
        sq.push_back(e);
    endtask

    // Called and returns at a negative edge; returns after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [2:0] rx,
                         input logic [2:0] ry, input logic [7:0] imm);
        int n = 0;
        ifc.cmd_op    = op;
        ifc.cmd_rx    = rx;
        ifc.cmd_ry    = ry;
        ifc.cmd_imm   = imm;
        ifc.cmd_valid = 1'b1;
        while (!ifc.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ifc.cmd_ready) begin
            chk("accept_timeout", 64'(ifc.cmd_ready), 64'd1);
            ifc.cmd_valid = 1'b0;
        end else begin
            accept_push(op, rx, ry, imm);
            @(posedge clk);
            #1 ifc.cmd_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(sq.size()), 64'd0);
    endtask

    // Monitor: every bank write and every done pulse is checked against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (ifc.bank_write_en) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", {53'd0, ifc.bank_rx_sel, ifc.bank_wr_data}, 64'h7FF);
                end else begin
                    logic [10:0] w;
                    w = wq.pop_front();
                    chk("write_addr_data", {53'd0, ifc.bank_rx_sel, ifc.bank_wr_data}, {53'd0, w});
                end
            end
            if (ifc.done) begin
                if (sq.size() == 0) begin
                    chk("unexpected_done", 64'(ifc.done), 64'd0);
                end else begin
                    exp_t e;
                    e = sq.pop_front();
                    chk("done_err", 64'(ifc.err), 64'(e.err));
                    chk("done_latency", 64'(cyc - e.acc), 64'(e.lat));
                    chk("regs_at_done", pack_bank(), e.snap);
                    chk("writes_outstanding", 64'(wq.size()), 64'd0);
                    chk("enables_in_done", {61'd0, ifc.bank_read_en, ifc.bank_write_en,
                                            ifc.bank_indirect_en}, 64'd0);
                end
            end
        end
    end

    initial begin
        int last, acc_cnt;
        rst = 1'b1;
        bank_init = 1'b1;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_op = 2'b00;
        ifc.cmd_rx = '0;
        ifc.cmd_ry = '0;
        ifc.cmd_imm = '0;
        for (int i = 0; i < NREG; i++) model[i] = 8'h00;

        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(ifc.cmd_ready), 64'd0);
        chk("rst_enables", {61'd0, ifc.bank_read_en, ifc.bank_write_en, ifc.bank_indirect_en}, 64'd0);
        chk("rst_done_err", {62'd0, ifc.done, ifc.err}, 64'd0);
        bank_init = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(ifc.cmd_ready), 64'd1);
        chk("post_rst_sel_data", {48'd0, 2'b00, ifc.bank_rx_sel, ifc.bank_ry_sel, ifc.bank_wr_data}, 64'd0);
        @(negedge clk);

        // WRITE_IMM r3=A5, then SWAP r1/r2.
        issue(WR, 3'd3, 3'd0, 8'hA5);
        drain();
        chk("r3_after_write_imm", 64'(bank[3]), 64'hA5);
        issue(WR, 3'd1, 3'd0, 8'h11);
        issue(WR, 3'd2, 3'd0, 8'h22);
        issue(SW, 3'd1, 3'd2, 8'h00);
        drain();
        chk("swap_r1_r2", {48'd0, bank[1], bank[2]}, 64'h2211);
        issue(SW, 3'd2, 3'd2, 8'h00);
        drain();
        chk("swap_same_reg", 64'(bank[2]), 64'h11);

        // Indirect load, in range then out of range.
        issue(WR, 3'd4, 3'd0, 8'h06);
        issue(WR, 3'd6, 3'd0, 8'h5C);
        issue(IL, 3'd0, 3'd4, 8'h00);
        drain();
        chk("ind_load_r0", 64'(bank[0]), 64'h5C);
        issue(WR, 3'd0, 3'd0, 8'h77);
        issue(WR, 3'd4, 3'd0, 8'h09);
        issue(IL, 3'd0, 3'd4, 8'h00);
        drain();
        chk("ind_load_oob_r0", 64'(bank[0]), 64'h77);

        // cmd_valid held high with COPY commands.
        last = -1;
        acc_cnt = 0;
        ifc.cmd_op = CP;
        ifc.cmd_rx = 3'($urandom);
        ifc.cmd_ry = 3'($urandom);
        ifc.cmd_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (ifc.cmd_ready) begin
                if (last >= 0) chk("copy_accept_spacing", 64'(cyc - last), 64'd3);
                last = cyc;
                acc_cnt++;
                accept_push(ifc.cmd_op, ifc.cmd_rx, ifc.cmd_ry, ifc.cmd_imm);
            end
            @(posedge clk);
            #1;
            ifc.cmd_rx = 3'($urandom);
            ifc.cmd_ry = 3'($urandom);
            @(negedge clk);
        end
        ifc.cmd_valid = 1'b0;
        chk("copy_accept_count", 64'(acc_cnt), 64'd4);
        drain();

        // Reset while a SWAP is in its second write.
        issue(WR, 3'd5, 3'd0, 8'h3C);
        issue(WR, 3'd7, 3'd0, 8'hC3);
        drain();
        issue(SW, 3'd5, 3'd7, 8'h00);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_swap2_write_en", 64'(ifc.bank_write_en), 64'd0);
        chk("rst_swap2_done", 64'(ifc.done), 64'd0);
        chk("rst_swap2_ready", 64'(ifc.cmd_ready), 64'd0);
        sq.delete();
        wq.delete();
        model[7] = 8'hC3;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_release_ready", 64'(ifc.cmd_ready), 64'd1);
        chk("rst_abandon_ry", 64'(bank[7]), 64'hC3);
        chk("rst_abandon_rx", 64'(bank[5]), 64'hC3);
        chk("rst_abandon_regs", pack_bank(), pack_model());
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_done_after_abort", 64'(ifc.done), 64'd0);
        end
        issue(WR, 3'd2, 3'd0, 8'h5A);
        drain();

        // Randomized commands; pointers are biased into range half the time.
        for (int k = 0; k < 40; k++) begin
            logic [1:0] op;
            logic [7:0] imm;
            op  = 2'($urandom);
            imm = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            issue(op, 3'($urandom), 3'($urandom), imm);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        chk("final_regs", pack_bank(), pack_model());
        chk("final_writes_outstanding", 64'(wq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/register_access_ctrl.md
REGISTER_ACCESS_CTRL -- requirements
Module: register_access_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the register data width.
REQ-002 Parameter SEL_W, default 3, SHALL set the register selector width (2**SEL_W registers).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  SHALL indicate a command is offered.
REQ-006 cmd_ready  output  1  SHALL indicate the block accepts a command this cycle.
REQ-007 cmd_op  input  2  SHALL select: 00 WRITE_IMM, 01 COPY, 10 IND_LOAD, 11 SWAP.
REQ-008 cmd_rx, cmd_ry  input  SEL_W each  SHALL be the destination and source register indices.
REQ-009 cmd_imm  input  DATA_W  SHALL be the immediate for WRITE_IMM.
REQ-010 bank_rx_sel, bank_ry_sel  output  SEL_W each  SHALL drive the bank selectors.
REQ-011 bank_read_en, bank_write_en, bank_indirect_en  output  1 each  SHALL drive the bank controls.
REQ-012 bank_wr_data  output  DATA_W  SHALL drive the bank write data.
REQ-013 bank_rx_data, bank_ry_data, bank_bus_data  input  DATA_W each  SHALL be the bank's combinational read outputs.
REQ-014 done  output  1  SHALL pulse one cycle when a command completes.
REQ-015 err  output  1  SHALL be valid with done; high when the command was aborted.

Function
REQ-016 FSM states SHALL be IDLE, EXEC, SWAP2, DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-017 In IDLE with cmd_valid=1, the block SHALL latch op, rx, ry, imm and go to EXEC on the next edge.
REQ-018 cmd_valid outside IDLE SHALL be ignored; no command is queued.
REQ-019 Bank controls SHALL be decoded from state and latched fields; in IDLE and DONE, read_en, write_en and indirect_en SHALL all be 0.
REQ-020 WRITE_IMM in EXEC: write_en=1, rx_sel=rx, wr_data=imm; next state DONE.
REQ-021 COPY in EXEC: read_en=1, ry_sel=ry, rx_sel=rx, wr_data=bank_bus_data, write_en=1; next DONE.
REQ-022 IND_LOAD in EXEC: as COPY plus indirect_en=1, so rx receives reg[reg[ry]].
REQ-023 IND_LOAD SHALL check bank_ry_data in EXEC; if it is >= 2**SEL_W, write_en SHALL stay 0, err SHALL be set, and the next state SHALL be DONE.
REQ-024 SWAP in EXEC: rx_sel=rx, ry_sel=ry, wr_data=bank_ry_data, write_en=1, internal tmp <= bank_rx_data; next SWAP2.
REQ-025 SWAP in SWAP2: rx_sel=ry, wr_data=tmp, write_en=1; next DONE.
REQ-026 SWAP with rx==ry SHALL run the same sequence and leave the register value unchanged.
REQ-027 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE; err SHALL be 0 for every non-aborted command.
REQ-028 Latency from the acceptance edge to the done pulse SHALL be 2 cycles, or 3 for SWAP; throughput SHALL be one command per 3 cycles (4 for SWAP).
REQ-029 At most one bank write SHALL occur per cycle, and write_en SHALL never be high in two consecutive cycles except EXEC->SWAP2.

Reset
REQ-030 While rst=1: state=IDLE, bank_read_en=0, bank_write_en=0, bank_indirect_en=0, done=0, err=0, tmp=0, cmd_ready=0.
REQ-031 After rst deasserts, cmd_ready SHALL be 1 and the selectors and wr_data SHALL be 0.
REQ-032 rst asserted mid-command SHALL immediately force write_en=0, and the command SHALL be abandoned with no done pulse; a SWAP interrupted after EXEC leaves only rx written.

Verification
REQ-033 WRITE_IMM rx=3, imm=0xA5 -> one write_en cycle with rx_sel=3, data 0xA5; done 2 cycles after acceptance; r3=0xA5.
REQ-034 r1=0x11, r2=0x22, SWAP rx=1, ry=2 -> two write cycles (0x22 to r1, then 0x11 to r2); done 3 cycles after acceptance.
REQ-035 r4=6, r6=0x5C, IND_LOAD rx=0, ry=4 -> r0=0x5C, err=0; with r4=0x09 instead -> no write, done with err=1, r0 unchanged.
REQ-036 cmd_valid held high for 10 cycles with COPY commands -> exactly one acceptance per 3 cycles; cmd_ready low in EXEC and DONE.
REQ-037 rst asserted in SWAP2 -> write_en drops at once, no done pulse, r(ry) unchanged; the next command completes normally.
